// File: rtl/ft_sync_tx.sv
// ft_sync_tx: byte FIFO plus output hold register that drains into an FT2232H/FT232H
// synchronous-245 write port. Bytes arriving while the FIFO is full are dropped and counted.
//   clk            : 60 MHz FT CLKOUT, all logic on the rising edge
//   nreset         : asynchronous active-low reset
//   in_data/valid  : byte stream from the packer, no backpressure
//   ft_txe_n       : FT TXE#, low when the device can take a byte
//   ft_wr_n/data   : registered FT WR# and data bus
//   level          : bytes in the FIFO, excluding the hold register
//   overflow       : sticky drop flag
//   overflow_clear : pulse that clears overflow and dropped_count
//   dropped_count  : saturating count of dropped bytes
module ft_sync_tx #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    input  logic                  ft_txe_n,
    output logic                  ft_wr_n,
    output logic [7:0]            ft_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  overflow_clear,
    output logic [15:0]           dropped_count
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [7:0]            hold_data_q, hold_data_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           dropped_q, dropped_d;
    logic                  accepted, pop, push, drop;

    always_comb begin
        accepted     = hold_valid_q && !ft_txe_n;
        // Refill the hold register whenever it is free or being emptied this edge.
        pop          = (!hold_valid_q || accepted) && count_q != '0;
        // A full FIFO still takes a byte when a pop frees a slot at the same edge.
        push         = in_valid && (count_q != FULL || pop);
        drop         = in_valid && count_q == FULL && !pop;
        count_d      = count_q + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
        wr_ptr_d     = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        hold_valid_d = pop || (hold_valid_q && !accepted);
        hold_data_d  = pop ? mem_q[rd_ptr_q] : hold_data_q;
        overflow_d   = drop || (overflow_q && !overflow_clear);
        // A drop coinciding with a clear leaves exactly that one drop recorded.
        dropped_d    = overflow_clear ? {15'd0, drop} :
                       (drop && dropped_q != 16'hFFFF) ? dropped_q + 16'd1 : dropped_q;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= 8'd0;
            overflow_q   <= 1'b0;
            dropped_q    <= 16'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            overflow_q   <= overflow_d;
            dropped_q    <= dropped_d;
        end
    end

    assign ft_wr_n       = !hold_valid_q;
    assign ft_data       = hold_data_q;
    assign level         = count_q;
    assign overflow      = overflow_q;
    assign dropped_count = dropped_q;
endmodule

// File: tb/tb_ft_sync_tx.sv
// tb_ft_sync_tx: randomized and directed stimulus against a queue-based reference model.
module tb_ft_sync_tx;
    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        nreset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        ft_txe_n;
    logic        ft_wr_n;
    logic [7:0]  ft_data;
    logic [9:0]  level;
    logic        overflow;
    logic        overflow_clear;
    logic [15:0] dropped_count;

    ft_sync_tx #(.DEPTH_LOG2(9)) dut (
        .clk(clk), .nreset(nreset), .in_data(in_data), .in_valid(in_valid),
        .ft_txe_n(ft_txe_n), .ft_wr_n(ft_wr_n), .ft_data(ft_data), .level(level),
        .overflow(overflow), .overflow_clear(overflow_clear), .dropped_count(dropped_count)
    );

    always #8 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // reference model: FIFO contents, hold register, flags, and the accepted-byte order
    logic [7:0] q_m [$];
    logic [7:0] sent [$];
    logic       m_hv;
    logic [7:0] m_hd;
    logic       m_ovf;
    int         m_drop;
    int         m_xfer;
    int         dut_xfer;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        sent.delete();
        m_hv = 1'b0;
        m_hd = 8'd0;
        m_ovf = 1'b0;
        m_drop = 0;
    endtask

    // One clock: drive at the falling edge, observe the transfer, model the edge, compare.
    task automatic step(input logic v, input logic [7:0] d, input logic txe, input logic clr);
        logic acc, pop, full;
        in_valid = v;
        in_data = d;
        ft_txe_n = txe;
        overflow_clear = clr;
        #1;
        if (!ft_wr_n && !txe) begin
            dut_xfer++;
            chk("order", ft_data, sent.size() != 0 ? int'(sent.pop_front()) : 256);
        end
        @(posedge clk);
        acc = m_hv && !txe;
        if (acc) m_xfer++;
        full = q_m.size() == DEPTH;
        pop = (!m_hv || acc) && q_m.size() > 0;
        if (pop) begin
            m_hd = q_m.pop_front();
            m_hv = 1'b1;
        end else if (acc) m_hv = 1'b0;
        if (v && (!full || pop)) begin
            q_m.push_back(d);
            sent.push_back(d);
        end
        if (clr) begin
            m_ovf = 1'b0;
            m_drop = 0;
        end
        if (v && full && !pop) begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
        end
        @(negedge clk);
        chk("wr_n", ft_wr_n, !m_hv);
        chk("data", ft_data, m_hd);
        chk("level", level, q_m.size());
        chk("overflow", overflow, m_ovf);
        chk("dropped", dropped_count, m_drop);
    endtask

    initial begin
        int lvl_max, x0;
        nreset = 1'b0;
        in_valid = 1'b0;
        in_data = 8'd0;
        ft_txe_n = 1'b1;
        overflow_clear = 1'b0;
        m_xfer = 0;
        dut_xfer = 0;
        model_reset();
        #5;
        chk("rst_wr_n", ft_wr_n, 1);
        chk("rst_data", ft_data, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", dropped_count, 0);
        @(negedge clk);
        nreset = 1'b1;
        step(0, 0, 0, 0);

        // streaming at full rate with the host ready
        lvl_max = 0;
        for (int i = 0; i < 256; i++) begin
            step(1, 8'(i), 0, 0);
            if (i == 0) chk("lat_edge1", ft_wr_n, 1);
            if (i == 1) chk("lat_edge2", ft_wr_n, 0);
            if (int'(level) > lvl_max) lvl_max = int'(level);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("stream_lvl_max_le2", lvl_max <= 2, 1);
        chk("stream_xfers", dut_xfer, 256);

        // host stall
        for (int i = 0; i < 20; i++) step(1, 8'hA0 + 8'(i), 1, 0);
        chk("stall_level", level, 19);
        chk("stall_data", ft_data, 8'hA0);
        chk("stall_wr_n", ft_wr_n, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        chk("stall_hold", ft_data, 8'hA0);
        x0 = dut_xfer;
        for (int i = 0; i < 25; i++) step(0, 0, 0, 0);
        chk("stall_xfers", dut_xfer - x0, 20);

        // fill past capacity
        for (int i = 0; i < 518; i++) step(1, 8'($urandom), 1, 0);
        chk("full_level", level, 512);
        chk("full_ovf", overflow, 1);
        chk("full_drop", dropped_count, 5);
        x0 = dut_xfer;
        for (int i = 0; i < 520; i++) step(0, 0, 0, 0);
        chk("full_drain_xfers", dut_xfer - x0, 513);
        chk("full_drain_level", level, 0);

        // full FIFO with a pop every edge absorbs a byte every edge
        for (int i = 0; i < 513; i++) step(1, 8'($urandom), 1, 0);
        chk("refill_level", level, 512);
        for (int i = 0; i < 50; i++) begin
            step(1, 8'($urandom), 0, 0);
            chk("simul_level", level, 512);
        end
        chk("simul_no_drop", dropped_count, 5);

        // clear colliding with a drop, clear alone, then saturation
        step(1, 8'h55, 1, 1);
        chk("coll_ovf", overflow, 1);
        chk("coll_drop", dropped_count, 1);
        step(0, 0, 1, 1);
        chk("clr_ovf", overflow, 0);
        chk("clr_drop", dropped_count, 0);
        for (int i = 0; i < 65540; i++) step(1, 8'($urandom), 1, 0);
        chk("sat_drop", dropped_count, 16'hFFFF);
        for (int i = 0; i < 520; i++) step(0, 0, 0, 0);
        chk("sat_drain_level", level, 0);

        // asynchronous reset mid-transfer with ten bytes queued
        for (int i = 0; i < 12; i++) step(1, 8'hC0 + 8'(i), 1, 0);
        step(0, 0, 0, 0);
        chk("pre_rst_level", level, 10);
        #3;
        nreset = 1'b0;
        #1;
        chk("async_wr_n", ft_wr_n, 1);
        chk("async_level", level, 0);
        chk("async_data", ft_data, 0);
        model_reset();
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        chk("no_stale", ft_wr_n, 1);

        // randomized mix, including bursts of host stall
        for (int i = 0; i < 3000; i++) begin
            logic txe;
            txe = (i / 200) % 2 == 1 ? $urandom_range(0, 7) != 0 : $urandom_range(0, 3) == 0;
            step($urandom_range(0, 3) != 0, 8'($urandom), txe, $urandom_range(0, 99) == 0);
        end
        for (int i = 0; i < 520; i++) step(0, 0, 0, 0);
        chk("xfer_total", dut_xfer, m_xfer);
        chk("sent_empty", sent.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ft_sync_tx.md
Name: ft_sync_tx

Overview:
- Downstream of the 12-to-8 sample packer. Buffers its byte stream in a FIFO.
- Drains the FIFO into an FT2232H/FT232H synchronous-245 FIFO write port.
- The packer has no backpressure, so this block absorbs bursts and host stalls.
- Bytes that cannot be stored are dropped and counted, never stalled.

Parameters:
DEPTH_LOG2, 9, FIFO depth = 2**DEPTH_LOG2 bytes (default 512)

Ports:
clk  in  1  single clock; FT 60 MHz CLKOUT domain; all logic on rising edge
nreset  in  1  asynchronous, active-low reset
in_data  in  8  byte from packer
in_valid  in  1  in_data valid this cycle; no ready signal
ft_txe_n  in  1  FT TXE#; low = device can accept a byte
ft_wr_n  out  1  FT WR#, registered
ft_data  out  8  FT data bus, registered
level  out  DEPTH_LOG2+1  bytes in FIFO, not counting the hold register
overflow  out  1  sticky: at least one byte dropped since reset/clear
overflow_clear  in  1  single-cycle pulse; clears overflow and dropped_count
dropped_count  out  16  bytes dropped, saturates at 16'hFFFF

Behaviour:
- Reset (nreset low, async): ft_wr_n=1, ft_data=0, level=0, overflow=0, dropped_count=0.
  - FIFO pointers and hold register empty; any byte in flight is discarded.
  - Outputs take reset values immediately, with no clock required.
  - Release is sampled on the first rising edge with nreset high.
- Structure: circular FIFO (wr_ptr, rd_ptr, count) feeding a single hold register (hold_valid, hold_data).
  - ft_data = hold_data; ft_wr_n = !hold_valid.
- Device acceptance: a byte transfers at a rising edge where ft_wr_n==0 and ft_txe_n==0 (both sampled at that edge).
  - ft_wr_n low with ft_txe_n high transfers nothing; hold_data and ft_wr_n stay unchanged.
- Hold update per edge:
  - if hold_valid && !accepted: keep.
  - else if count>0: pop FIFO into hold (hold_valid=1).
  - else: hold_valid=0.
- Pop: occurs whenever hold is empty or accepted this edge, and count>0. The pop does not depend on ft_txe_n.
- Push: when in_valid, and either count<DEPTH or a pop occurs at the same edge.
  - Push and pop at the same edge: count unchanged, and both pointers advance modulo DEPTH.
- Drop: in_valid with count==DEPTH and no pop at that edge.
  - The byte is discarded and overflow sets to 1.
  - dropped_count increments, saturating at 16'hFFFF.
- overflow_clear: zeroes overflow and dropped_count.
  - If a drop happens at the same edge: overflow=1, dropped_count=1.
- No FIFO bypass. Latency with an empty pipeline: in_valid at edge N -> byte in FIFO after N -> ft_wr_n=0 and ft_data=byte after N+1 -> transfers at edge N+2 if ft_txe_n=0.
- Sustained throughput: 1 byte/cycle while ft_txe_n stays low.
- Ordering: bytes leave in exactly the order accepted. There is no duplication or loss except counted drops.
- Pointer wrap at DEPTH is seamless; level ranges 0..DEPTH inclusive.
- level updates at every edge and reflects the post-edge count.

Test Plan:
- Reset: assert nreset low mid-transfer with FIFO holding 10 bytes, no clock edge -> ft_wr_n=1, level=0 immediately; after release, no stale bytes appear on ft_data.
- Latency/stream: ft_txe_n=0; push 0x00..0xFF on consecutive cycles -> first ft_wr_n=0 two edges after first push; 256 transfers in order, one per cycle; level never exceeds 2.
- Host stall: ft_txe_n=1 while pushing 20 bytes (A0..B3) -> ft_wr_n=0 holding 0xA0 constantly, level=19; release ft_txe_n -> A0..B3 transfer in order, no duplicate of 0xA0.
- Full/drop: ft_txe_n=1, push 1+512+5 bytes -> level=512, overflow=1, dropped_count=5; release -> exactly 513 bytes out, the first 513 pushed.
- Full with simultaneous pop: FIFO full, ft_txe_n=0, in_valid every cycle -> no drops, level stays 512, output sequence continuous.
- Clear collision: overflow_clear pulse at the same edge as a drop -> overflow=1, dropped_count=1; clear alone afterwards -> both 0. Saturation: force 65540 drops -> dropped_count=16'hFFFF.
